// File: rtl/vga_pattern_gen.sv
// Pixel-generation stage between the VGA sync timing unit and the 8-bit RGB DAC.
// Registers RGB together with delayed syncs and animates a bouncing box once per frame.
module vga_pattern_gen #(
  parameter int H_DISPLAY = 640,
  parameter int V_DISPLAY = 480,
  parameter int BOX_SIZE  = 32,
  parameter int STEP      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p_tick,
  input  logic       video_on,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [1:0] mode,
  input  logic [7:0] fg,
  output logic       hsync,
  output logic       vsync,
  output logic [7:0] rgb,
  output logic       frame_pulse
);

  typedef enum logic [1:0] {
    MODE_BARS     = 2'd0,
    MODE_CHECKER  = 2'd1,
    MODE_GRADIENT = 2'd2,
    MODE_BOX      = 2'd3
  } mode_t;

  // Forward means right for the x axis and down for the y axis.
  typedef enum logic {
    DIR_FWD  = 1'b0,
    DIR_BACK = 1'b1
  } dir_t;

  localparam logic [9:0]  X_LIMIT = 10'(H_DISPLAY - BOX_SIZE);
  localparam logic [9:0]  Y_LIMIT = 10'(V_DISPLAY - BOX_SIZE);
  localparam logic [9:0]  STEP10  = 10'(STEP);
  localparam logic [10:0] STEP11  = 11'(STEP);
  localparam logic [10:0] BOX11   = 11'(BOX_SIZE);
  localparam logic [9:0]  BAR_W   = 10'(H_DISPLAY / 8);
  localparam logic [9:0]  V_LINE  = 10'(V_DISPLAY);

  logic [9:0] box_x, box_y, box_x_next, box_y_next;
  dir_t       dir_x, dir_y, dir_x_next, dir_y_next;
  logic [7:0] frame_cnt;
  mode_t      mode_reg;
  logic       frame_point;
  logic       in_box;
  logic [2:0] bar;
  logic [7:0] pixel;

  assign frame_point = p_tick && (x == 10'd0) && (y == V_LINE);

  // Box motion: clamp to the edge and reverse on the frame that would cross it.
  always_comb begin
    box_x_next = box_x;
    dir_x_next = dir_x;
    box_y_next = box_y;
    dir_y_next = dir_y;
    if (dir_x == DIR_FWD) begin
      if ({1'b0, box_x} + STEP11 >= {1'b0, X_LIMIT}) begin
        box_x_next = X_LIMIT;
        dir_x_next = DIR_BACK;
      end else begin
        box_x_next = box_x + STEP10;
      end
    end else begin
      if ({1'b0, box_x} <= STEP11) begin
        box_x_next = 10'd0;
        dir_x_next = DIR_FWD;
      end else begin
        box_x_next = box_x - STEP10;
      end
    end
    if (dir_y == DIR_FWD) begin
      if ({1'b0, box_y} + STEP11 >= {1'b0, Y_LIMIT}) begin
        box_y_next = Y_LIMIT;
        dir_y_next = DIR_BACK;
      end else begin
        box_y_next = box_y + STEP10;
      end
    end else begin
      if ({1'b0, box_y} <= STEP11) begin
        box_y_next = 10'd0;
        dir_y_next = DIR_FWD;
      end else begin
        box_y_next = box_y - STEP10;
      end
    end
  end

  // Box bounds use 11-bit sums so a box at the right/bottom edge cannot wrap.
  assign in_box = ({1'b0, x} >= {1'b0, box_x}) && ({1'b0, x} < {1'b0, box_x} + BOX11) &&
                  ({1'b0, y} >= {1'b0, box_y}) && ({1'b0, y} < {1'b0, box_y} + BOX11);

  assign bar = 3'(x / BAR_W);

  always_comb begin
    pixel = 8'h00;
    case (mode_reg)
      MODE_BARS:     pixel = {{3{bar[2]}}, {3{bar[1]}}, {2{bar[0]}}};
      MODE_CHECKER:  pixel = (x[5] ^ y[5]) ? fg : 8'h00;
      MODE_GRADIENT: pixel = x[7:0] + frame_cnt;
      default:       pixel = in_box ? fg : 8'h00;
    endcase
    if (!video_on) pixel = 8'h00;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb   <= 8'h00;
      hsync <= 1'b0;
      vsync <= 1'b0;
    end else if (p_tick) begin
      rgb   <= pixel;
      hsync <= hsync_in;
      vsync <= vsync_in;
    end
  end

  // Mode is only latched at the start of vertical blanking to avoid tearing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_pulse <= 1'b0;
      box_x       <= 10'd0;
      box_y       <= 10'd0;
      dir_x       <= DIR_FWD;
      dir_y       <= DIR_FWD;
      frame_cnt   <= 8'd0;
      mode_reg    <= MODE_BARS;
    end else begin
      frame_pulse <= frame_point;
      if (frame_point) begin
        box_x     <= box_x_next;
        box_y     <= box_y_next;
        dir_x     <= dir_x_next;
        dir_y     <= dir_y_next;
        frame_cnt <= frame_cnt + 8'd1;
        mode_reg  <= mode_t'(mode);
      end
    end
  end

endmodule
